tl_xbar_arb2: RTL
=================

Name: tl_xbar_arb2

Overview:
Two-client TileLink-UH A/D arbiter feeding one manager port. It sits in front of the single-output crossbar stage on the peripheral bus. The A channel is shared round-robin, and the grant is locked for the length of a multi-beat Put burst. The client index is tagged into the source MSB, and that bit steers D responses back to the right client. Per-client outstanding-request limits are enforced.

Parameters:
SRC_W, 6, client source ID width; manager side uses SRC_W+1.
MAX_INFLIGHT, 4, maximum outstanding requests per client (1..15).
BEAT_BYTES_LOG2, 3, log2 of data bus bytes (64-bit data).

Ports:
clock  in  1  sole clock, rising edge.
reset  in  1  asynchronous, active-low (0 = in reset).
in<i>_a_valid / in<i>_a_ready  in/out  1  client i A handshake, i in {0,1}.
in<i>_a_opcode, in<i>_a_size  in  3,3  TL opcode, log2 bytes.
in<i>_a_source  in  SRC_W  client source ID.
in<i>_a_address, in<i>_a_mask, in<i>_a_data  in  32,8,64  A payload.
in<i>_d_valid / in<i>_d_ready  out/in  1  client i D handshake.
in<i>_d_opcode, in<i>_d_size, in<i>_d_source  out  3,3,SRC_W  D fields, tag stripped.
in<i>_d_denied, in<i>_d_corrupt, in<i>_d_data  out  1,1,64  D payload.
out_a_valid / out_a_ready  out/in  1  manager A handshake.
out_a_opcode, out_a_size, out_a_source  out  3,3,SRC_W+1  source = {i, in<i>_a_source}.
out_a_address, out_a_mask, out_a_data  out  32,8,64  muxed payload.
out_d_valid / out_d_ready  in/out  1  manager D handshake.
out_d_opcode, out_d_size, out_d_source, out_d_denied, out_d_corrupt, out_d_data  in  3,3,SRC_W+1,1,1,64.

Behaviour:
- Beat count: PutFull(0) and PutPartial(1) on A, and AccessAckData(1) on D, use max(1, 2^(size-3)) beats. All other opcodes use 1 beat.
- A states are IDLE and BURST. In IDLE, the grant is chosen combinationally among eligible clients: valid and inflight<MAX_INFLIGHT.
- Round-robin: priority goes to the client not granted last. The pointer resets to prefer client 0 and updates on each first-beat fire.
- A data path is zero latency: out_a_valid = granted in_a_valid, and in<g>_a_ready = out_a_ready. The non-granted ready is 0.
- A first-beat fire of a multi-beat request enters BURST, holding the grant, and loads remaining = beats-1. Each fire decrements it. The last fire returns to IDLE. Only the granted client is observed while in BURST.
- Inflight counter i increments on the first A beat fire of client i. It decrements on the last D beat fire routed to client i. On a simultaneous inc and dec the counter is unchanged. The counter never exceeds MAX_INFLIGHT. A D response arriving with counter 0 is a protocol error: the counter saturates at 0.
- D routing is zero latency:
  - in<k>_d_valid = out_d_valid && out_d_source[SRC_W]==k.
  - out_d_ready = in<k>_d_ready of the addressed client.
  - in<k>_d_source = out_d_source[SRC_W-1:0]. Other D fields are broadcast.
- A D-beat counter tracks multi-beat responses. D bursts are contiguous per TileLink.
- Clients must hold A stable while valid && !ready. The arbiter does not re-arbitrate while out_a_valid && !out_a_ready.
- The grant is registered when a request is presented and not accepted, so the choice is stable until fire.
- Reset (async, any time, including mid-burst): state=IDLE, pointer=0, counters=0, held grant cleared.
- Reset values of outputs: all valids 0, in<i>_a_ready 0, out_d_ready 0. Payload outputs follow the mux with selection=client 0.

Decomposition:
- Package tl_arb_pkg holds:
  - opcode constants: PutFull=0, PutPartial=1, Get=4, AccessAck=0, AccessAckData=1;
  - the state enum {IDLE, BURST};
  - function num_beats(opcode, size, is_d).
- One sub-module: tl_beat_counter. It loads the beat count on the first fire and flags the last beat. It is instantiated for A and for D.

Test Plan:
- Both clients issue a single-beat Get (src 5, src 9) simultaneously after reset → client 0 first with out_a_source=0x05, then client 1 with 0x49. Responses with source 0x49 and then 0x05 route to client 1 and client 0, with source 9 and 5.
- Client 1 issues PutFull size=5 (4 beats) while client 0 asserts Get at beat 2 → out_a carries 4 contiguous client-1 beats, and client 0 is granted on the next cycle.
- Client 0 issues 4 Gets with no responses, MAX_INFLIGHT=4 → 5th Get held with in0_a_ready=0. After one AccessAck to source 0x0x, it is accepted the cycle after.
- AccessAckData size=4 (2 beats) to client 1 with in1_d_ready toggling 1,0,1 → out_d_ready mirrors the toggling. Inflight decrements only on beat 2.
- reset asserted low at beat 2 of a 4-beat Put → all valids and readies read 0 immediately. After release, the next request arbitrates from IDLE with client 0 preferred.
- Continuous Gets from both clients for 20 cycles with out_a_ready=1 → grants alternate 0,1,0,1 and there is no starvation.

Source files
------------

// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UH constants, the A-channel state type and small helpers
// used by the two-client A/D arbiter.
package tl_arb_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } a_state_e;

    // Data-carrying messages span 2^(size-beat_log2) beats, everything else is one beat.
    function automatic logic [4:0] num_beats(input logic [2:0] opcode,
                                             input logic [2:0] size,
                                             input logic       is_d,
                                             input logic [2:0] beat_log2);
        logic       multi;
        logic [4:0] beats;
        if (is_d) begin
            multi = (opcode == ACCESS_ACK_DATA);
        end else begin
            multi = (opcode == PUT_FULL) || (opcode == PUT_PARTIAL);
        end
        beats = 5'd1;
        if (multi && (size > beat_log2)) begin
            beats = 5'd1 << (size - beat_log2);
        end
        return beats;
    endfunction

    // A simultaneous increment and decrement cancel; both ends saturate.
    function automatic logic [3:0] next_inflight(input logic [3:0] cnt,
                                                 input logic       inc,
                                                 input logic       dec,
                                                 input logic [3:0] max_cnt);
        logic [3:0] n;
        n = cnt;
        if (inc && !dec && (cnt < max_cnt)) begin
            n = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'd0)) begin
            n = cnt - 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Tracks the position inside a multi-beat TileLink message: loads the beat
// count on the first fire and flags the final beat.
module tl_beat_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       fire,
    input  logic [4:0] beats,
    output logic       last
);
    import tl_arb_pkg::*;

    logic [3:0] remaining_q;
    logic [3:0] remaining_d;

    always_comb begin
        remaining_d = remaining_q;
        if (fire) begin
            if (remaining_q == 4'd0) begin
                remaining_d = 4'(beats - 5'd1);
            end else begin
                remaining_d = remaining_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_q <= 4'd0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

    assign last = (remaining_q == 4'd0) ? (beats == 5'd1) : (remaining_q == 4'd1);

endmodule

// File: rtl/tl_xbar_arb2.sv
// Two-client TileLink-UH A/D arbiter: round-robin A with burst locking,
// client index tagged into the source MSB, D routed back by that bit.
module tl_xbar_arb2 #(
    parameter int SRC_W           = 6,
    parameter int MAX_INFLIGHT    = 4,
    parameter int BEAT_BYTES_LOG2 = 3
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               in0_a_valid,
    output logic               in0_a_ready,
    input  logic [2:0]         in0_a_opcode,
    input  logic [2:0]         in0_a_size,
    input  logic [SRC_W-1:0]   in0_a_source,
    input  logic [31:0]        in0_a_address,
    input  logic [7:0]         in0_a_mask,
    input  logic [63:0]        in0_a_data,
    output logic               in0_d_valid,
    input  logic               in0_d_ready,
    output logic [2:0]         in0_d_opcode,
    output logic [2:0]         in0_d_size,
    output logic [SRC_W-1:0]   in0_d_source,
    output logic               in0_d_denied,
    output logic               in0_d_corrupt,
    output logic [63:0]        in0_d_data,

    input  logic               in1_a_valid,
    output logic               in1_a_ready,
    input  logic [2:0]         in1_a_opcode,
    input  logic [2:0]         in1_a_size,
    input  logic [SRC_W-1:0]   in1_a_source,
    input  logic [31:0]        in1_a_address,
    input  logic [7:0]         in1_a_mask,
    input  logic [63:0]        in1_a_data,
    output logic               in1_d_valid,
    input  logic               in1_d_ready,
    output logic [2:0]         in1_d_opcode,
    output logic [2:0]         in1_d_size,
    output logic [SRC_W-1:0]   in1_d_source,
    output logic               in1_d_denied,
    output logic               in1_d_corrupt,
    output logic [63:0]        in1_d_data,

    output logic               out_a_valid,
    input  logic               out_a_ready,
    output logic [2:0]         out_a_opcode,
    output logic [2:0]         out_a_size,
    output logic [SRC_W:0]     out_a_source,
    output logic [31:0]        out_a_address,
    output logic [7:0]         out_a_mask,
    output logic [63:0]        out_a_data,

    input  logic               out_d_valid,
    output logic               out_d_ready,
    input  logic [2:0]         out_d_opcode,
    input  logic [2:0]         out_d_size,
    input  logic [SRC_W:0]     out_d_source,
    input  logic               out_d_denied,
    input  logic               out_d_corrupt,
    input  logic [63:0]        out_d_data
);
    import tl_arb_pkg::*;

    localparam logic [3:0] MAX_CNT  = 4'(MAX_INFLIGHT);
    localparam logic [2:0] BEAT_LOG = 3'(BEAT_BYTES_LOG2);

    a_state_e   state_q, state_d;
    logic       rr_q, rr_d;
    logic       grant_q, grant_d;
    logic       held_q, held_d;
    logic [3:0] inflight0_q, inflight0_d;
    logic [3:0] inflight1_q, inflight1_d;

    logic       elig0, elig1, locked;
    logic       sel, sel_active;
    logic       a_fire, a_first, a_last;
    logic       d_fire, d_last, d_to1;
    logic [4:0] a_beats, d_beats;

    // Grant is frozen during a burst or while an offered beat waits for ready.
    always_comb begin
        elig0  = in0_a_valid && (inflight0_q < MAX_CNT);
        elig1  = in1_a_valid && (inflight1_q < MAX_CNT);
        locked = (state_q == BURST) || held_q;
        if (!reset) begin
            sel        = 1'b0;
            sel_active = 1'b0;
        end else if (locked) begin
            sel        = grant_q;
            sel_active = 1'b1;
        end else begin
            sel        = (elig0 && elig1) ? rr_q : elig1;
            sel_active = elig0 || elig1;
        end
    end

    always_comb begin
        out_a_valid   = sel_active && (sel ? in1_a_valid : in0_a_valid);
        in0_a_ready   = sel_active && !sel && out_a_ready;
        in1_a_ready   = sel_active && sel && out_a_ready;
        out_a_opcode  = sel ? in1_a_opcode  : in0_a_opcode;
        out_a_size    = sel ? in1_a_size    : in0_a_size;
        out_a_source  = {sel, (sel ? in1_a_source : in0_a_source)};
        out_a_address = sel ? in1_a_address : in0_a_address;
        out_a_mask    = sel ? in1_a_mask    : in0_a_mask;
        out_a_data    = sel ? in1_a_data    : in0_a_data;
    end

    always_comb begin
        d_to1         = out_d_source[SRC_W];
        in0_d_valid   = reset && out_d_valid && !d_to1;
        in1_d_valid   = reset && out_d_valid && d_to1;
        out_d_ready   = reset && (d_to1 ? in1_d_ready : in0_d_ready);
        in0_d_opcode  = out_d_opcode;
        in0_d_size    = out_d_size;
        in0_d_source  = out_d_source[SRC_W-1:0];
        in0_d_denied  = out_d_denied;
        in0_d_corrupt = out_d_corrupt;
        in0_d_data    = out_d_data;
        in1_d_opcode  = out_d_opcode;
        in1_d_size    = out_d_size;
        in1_d_source  = out_d_source[SRC_W-1:0];
        in1_d_denied  = out_d_denied;
        in1_d_corrupt = out_d_corrupt;
        in1_d_data    = out_d_data;
    end

    assign a_fire  = out_a_valid && out_a_ready;
    assign a_first = (state_q == IDLE);
    assign d_fire  = out_d_valid && out_d_ready;
    assign a_beats = num_beats(out_a_opcode, out_a_size, 1'b0, BEAT_LOG);
    assign d_beats = num_beats(out_d_opcode, out_d_size, 1'b1, BEAT_LOG);

    tl_beat_counter u_a_beats (
        .clock (clock),
        .reset (reset),
        .fire  (a_fire),
        .beats (a_beats),
        .last  (a_last)
    );

    tl_beat_counter u_d_beats (
        .clock (clock),
        .reset (reset),
        .fire  (d_fire),
        .beats (d_beats),
        .last  (d_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (a_fire && !a_last) state_d = BURST;
            BURST: if (a_fire && a_last)  state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_d    = rr_q;
        grant_d = grant_q;
        held_d  = (state_q == IDLE) && out_a_valid && !out_a_ready;
        if (sel_active) begin
            grant_d = sel;
        end
        if (a_fire && a_first) begin
            rr_d = ~sel;
        end
        inflight0_d = next_inflight(inflight0_q, a_fire && a_first && !sel,
                                    d_fire && d_last && !d_to1, MAX_CNT);
        inflight1_d = next_inflight(inflight1_q, a_fire && a_first && sel,
                                    d_fire && d_last && d_to1, MAX_CNT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q        <= 1'b0;
            grant_q     <= 1'b0;
            held_q      <= 1'b0;
            inflight0_q <= 4'd0;
            inflight1_q <= 4'd0;
        end else begin
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            held_q      <= held_d;
            inflight0_q <= inflight0_d;
            inflight1_q <= inflight1_d;
        end
    end

endmodule
